qrd_feed_ctrl: RTL and testbench

QRD_FEED_CTRL -- requirements
Module: qrd_feed_ctrl

---
 rtl/qrd_pkg.sv | 20 ++
 rtl/feed_skew.sv | 24 ++
 rtl/qrd_feed_ctrl.sv | 101 ++++++++++
 tb/tb_qrd_feed_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD-RLS array feed controller.
// Holds the controller state encoding, default array sizing and a width helper.
package qrd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam int DEFAULT_N   = 4;
    localparam int DEFAULT_LAT = 21;

    // Bits needed to index `count` distinct values, never less than one.
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/feed_skew.sv
// Skew shift register: bit 0 captures the accept strobe, and each higher bit
// repeats the bit below it one cycle later, producing the per-column load wavefront.
module feed_skew #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= (q << 1) | N'(din);
        end
    end

endmodule

// File: rtl/qrd_feed_ctrl.sv
// Frame controller that feeds K input rows into an N-column QRD-RLS array,
// then waits out the array latency plus skew before pulsing done.
module qrd_feed_ctrl
    import qrd_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int K   = 16,
    parameter int LAT = DEFAULT_LAT,
    localparam int RW = width_of(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  feed_en,
    output logic          sof,
    output logic [RW-1:0] row_idx,
    output logic          busy,
    output logic          done
);

    localparam int            CW         = width_of(LAT + N);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(LAT + N - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(K - 1);

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          last_row;
    logic [CW-1:0] drain_cnt;

    assign in_ready = (state == FEED);
    assign accept   = in_valid & in_ready;
    assign last_row = accept && (row_idx == ROW_LAST);
    assign sof      = accept && (row_idx == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FEED;
            FEED:    if (last_row) state_next = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // row_idx wraps to 0 on the final row, so it already reads 0 in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx <= '0;
        end else if (abort) begin
            row_idx <= '0;
        end else if (state == IDLE && start) begin
            row_idx <= '0;
        end else if (last_row) begin
            row_idx <= '0;
        end else if (accept) begin
            row_idx <= row_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (abort) begin
            drain_cnt <= '0;
        end else if (last_row) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    feed_skew #(
        .N(N)
    ) u_skew (
        .clk (clk),
        .rst (rst),
        .clr (abort),
        .din (accept),
        .q   (feed_en)
    );

endmodule

// File: tb/tb_qrd_feed_ctrl.sv
// Self-checking bench: a K=4 and a K=1 controller share stimulus and are
// compared every cycle against a frame-level reference model.
module tb_qrd_feed_ctrl;

    localparam int N    = 4;
    localparam int K    = 4;
    localparam int K1   = 1;
    localparam int LAT  = 21;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst, start, abort, in_valid;

    logic         rdy_a, sof_a, busy_a, done_a;
    logic [N-1:0] fe_a;
    logic [1:0]   row_a;
    logic         rdy_b, sof_b, busy_b, done_b;
    logic [N-1:0] fe_b;
    logic [0:0]   row_b;

    always #5 clk = ~clk;

    qrd_feed_ctrl #(.N(N), .K(K), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
        .in_ready(rdy_a), .feed_en(fe_a), .sof(sof_a), .row_idx(row_a),
        .busy(busy_a), .done(done_a)
    );

    qrd_feed_ctrl #(.N(N), .K(K1), .LAT(LAT)) dut_k1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
        .in_ready(rdy_b), .feed_en(fe_b), .sof(sof_b), .row_idx(row_b),
        .busy(busy_b), .done(done_b)
    );

    // Frame-level view: rows taken so far, cycles of drain left, and the cycle
    // of the most recent abort/reset (which wipes any in-flight feed pulses).
    typedef struct {
        bit in_frame;
        bit done_flag;
        int rows;
        int drain_left;
        int kill_cyc;
    } mdl_t;

    mdl_t m [2];
    bit   acc_log [2][MAXC];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   done_cyc [2];
    int   n_done [2];
    int   first_fe3;

    function automatic int kof(input int i);
        return (i == 0) ? K : K1;
    endfunction

    function automatic bit exp_ready(input int i);
        return m[i].in_frame && (m[i].rows < kof(i));
    endfunction

    // feed_en[j] is high when an accept happened exactly j+1 cycles ago and no abort since.
    function automatic int exp_feed(input int i);
        int v = 0;
        for (int j = 0; j < N; j++) begin
            int a = cyc - j - 1;
            if (a >= 0 && a < MAXC && a > m[i].kill_cyc && acc_log[i][a]) v |= (1 << j);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_kill(input int i);
        m[i].in_frame   = 1'b0;
        m[i].done_flag  = 1'b0;
        m[i].rows       = 0;
        m[i].drain_left = 0;
        m[i].kill_cyc   = cyc;
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 2; i++) begin
            string pre = (i == 0) ? "k4_" : "k1_";
            bit    ev  = exp_ready(i) && in_valid;
            check({pre, "ready"}, (i == 0) ? 32'(rdy_a) : 32'(rdy_b), 32'(exp_ready(i)));
            check({pre, "sof"},   (i == 0) ? 32'(sof_a) : 32'(sof_b), 32'(ev && m[i].rows == 0));
            check({pre, "row"},   (i == 0) ? 32'(row_a) : 32'(row_b), 32'(m[i].rows % kof(i)));
            check({pre, "busy"},  (i == 0) ? 32'(busy_a) : 32'(busy_b), 32'(m[i].in_frame || m[i].done_flag));
            check({pre, "done"},  (i == 0) ? 32'(done_a) : 32'(done_b), 32'(m[i].done_flag));
            check({pre, "feed"},  (i == 0) ? 32'(fe_a) : 32'(fe_b), 32'(exp_feed(i)));
        end
        if (done_a === 1'b1) begin done_cyc[0] = cyc; n_done[0]++; end
        if (done_b === 1'b1) begin done_cyc[1] = cyc; n_done[1]++; end
        if (fe_a[N-1] === 1'b1 && first_fe3 < 0) first_fe3 = cyc;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit acc = exp_ready(i) && in_valid;
            if (cyc < MAXC) acc_log[i][cyc] = acc;
            if (rst || abort) begin
                model_kill(i);
            end else if (m[i].done_flag) begin
                m[i].done_flag = 1'b0;
            end else if (!m[i].in_frame) begin
                if (start) begin
                    m[i].in_frame = 1'b1;
                    m[i].rows     = 0;
                end
            end else if (m[i].rows < kof(i)) begin
                if (acc) begin
                    m[i].rows++;
                    if (m[i].rows == kof(i)) m[i].drain_left = LAT + N;
                end
            end else begin
                m[i].drain_left--;
                if (m[i].drain_left == 0) begin
                    m[i].in_frame  = 1'b0;
                    m[i].done_flag = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    initial begin
        int s;
        int guard;
        int nd;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        cyc = 0; n_checks = 0; n_errors = 0; first_fe3 = -1;
        for (int i = 0; i < 2; i++) begin
            model_kill(i);
            m[i].kill_cyc = -1;
            done_cyc[i] = -1;
            n_done[i] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic frame, in_valid held high.
        start = 1'b1; in_valid = 1'b1; s = cyc; first_fe3 = -1;
        done_cyc[0] = -1; done_cyc[1] = -1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        check("a_done_latency", 32'(done_cyc[0] - s), 32'd30);
        check("a_fe3_first", 32'(first_fe3 - s), 32'd5);
        check("a_k1_done_latency", 32'(done_cyc[1] - (s + 1)), 32'(LAT + N + 1));

        // Stall for 3 cycles after the second accept.
        start = 1'b1; s = cyc; done_cyc[0] = -1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("b_row_hold", 32'(row_a), 32'd2);
        in_valid = 1'b1;
        repeat (40) tick();
        check("b_done_latency", 32'(done_cyc[0] - s), 32'd33);

        // Abort in DRAIN with the counter at 10, then a full frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(m[0].in_frame && m[0].rows == K && m[0].drain_left == 11) && guard < 200) begin
            tick();
            guard++;
        end
        check("c_reach_drain", 32'(guard < 200), 32'd1);
        nd = n_done[0];
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c_idle_after_abort", 32'(busy_a), 32'd0);
        repeat (40) tick();
        check("c_no_done", 32'(n_done[0]), 32'(nd));
        start = 1'b1; s = cyc; done_cyc[0] = -1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("c_restart_done", 32'(done_cyc[0] - s), 32'd30);

        // start during FEED and during DONE is ignored; start+abort in IDLE stays IDLE.
        nd = n_done[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!m[0].done_flag && guard < 200) begin
            tick();
            guard++;
        end
        check("d_reach_done", 32'(guard < 200), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("d_one_done", 32'(n_done[0] - nd), 32'd1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("d_start_abort_idle", 32'(busy_a), 32'd0);
        tick();

        // Asynchronous reset mid-FEED at row_idx 2, then a normal frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("e_row_before_rst", 32'(row_a), 32'd2);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) model_kill(i);
        #1;
        check("e_rst_busy", 32'(busy_a), 32'd0);
        check("e_rst_ready", 32'(rdy_a), 32'd0);
        check("e_rst_feed", 32'(fe_a), 32'd0);
        check("e_rst_row", 32'(row_a), 32'd0);
        check("e_rst_sof", 32'(sof_a), 32'd0);
        check("e_rst_done", 32'(done_a), 32'd0);
        tick();
        rst = 1'b0;
        start = 1'b1; s = cyc; done_cyc[0] = -1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("e_done_after_rst", 32'(done_cyc[0] - s), 32'd30);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom_range(0, 9) == 0);
            abort    = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            tick();
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
